// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and IDLE->CMD(->RESP) sequencer in front of the
// single-ported data memory shared by the core (C) and DMA/debug (D) masters.
module data_mem_arbiter #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     C_Req,
  input  logic [ADDRESS_WIDTH-1:0] C_Addr,
  input  logic [DATA_WIDTH-1:0]    C_WData,
  input  logic                     C_MemRead,
  input  logic                     C_MemWrite,
  input  logic [2:0]               C_Funct3,
  output logic                     C_Gnt,
  output logic                     C_RValid,
  output logic [DATA_WIDTH-1:0]    C_RData,
  input  logic                     D_Req,
  input  logic [ADDRESS_WIDTH-1:0] D_Addr,
  input  logic [DATA_WIDTH-1:0]    D_WData,
  input  logic                     D_MemRead,
  input  logic                     D_MemWrite,
  input  logic [2:0]               D_Funct3,
  output logic                     D_Gnt,
  output logic                     D_RValid,
  output logic [DATA_WIDTH-1:0]    D_RData,
  output logic [ADDRESS_WIDTH-1:0] M_Address,
  output logic [DATA_WIDTH-1:0]    M_WriteData,
  output logic                     M_MemRead,
  output logic                     M_MemWrite,
  output logic [2:0]               M_Funct3,
  input  logic [DATA_WIDTH-1:0]    M_ReadData
);

  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

  state_t                   r_state;
  logic                     r_last_d;
  logic                     r_port_d;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [2:0]               r_funct3;
  logic                     r_mrd, r_mwr;
  logic                     r_c_rv, r_d_rv;
  logic [DATA_WIDTH-1:0]    r_c_rdata, r_d_rdata;

  logic w_idle, w_c_win, w_d_win, w_win_rd, w_win_wr;

  // Grant is gated by reset so nothing is acknowledged while held in reset.
  assign w_idle   = (r_state == IDLE) && rst_n;
  assign w_c_win  = w_idle && C_Req && (!D_Req || r_last_d);
  assign w_d_win  = w_idle && D_Req && !w_c_win;
  assign w_win_rd = w_d_win ? D_MemRead : C_MemRead;
  assign w_win_wr = (w_d_win ? D_MemWrite : C_MemWrite) && !w_win_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b1;
      r_port_d  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_funct3  <= '0;
      r_mrd     <= 1'b0;
      r_mwr     <= 1'b0;
      r_c_rv    <= 1'b0;
      r_d_rv    <= 1'b0;
      r_c_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      r_c_rv <= 1'b0;
      r_d_rv <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_c_win || w_d_win) begin
            r_state  <= CMD;
            r_last_d <= w_d_win;
            r_port_d <= w_d_win;
            r_addr   <= w_d_win ? D_Addr   : C_Addr;
            r_wdata  <= w_d_win ? D_WData  : C_WData;
            r_funct3 <= w_d_win ? D_Funct3 : C_Funct3;
            r_mrd    <= w_win_rd;
            r_mwr    <= w_win_wr;
          end
        end
        CMD: begin
          r_mrd <= 1'b0;
          r_mwr <= 1'b0;
          // Strobe registers double as the op record: only reads need RESP.
          if (r_mrd) begin
            r_state <= RESP;
            if (r_port_d) begin
              r_d_rdata <= M_ReadData;
              r_d_rv    <= 1'b1;
            end else begin
              r_c_rdata <= M_ReadData;
              r_c_rv    <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign C_Gnt       = w_c_win;
  assign D_Gnt       = w_d_win;
  assign C_RValid    = r_c_rv;
  assign D_RValid    = r_d_rv;
  assign C_RData     = r_c_rdata;
  assign D_RData     = r_d_rdata;
  assign M_Address   = r_addr;
  assign M_WriteData = r_wdata;
  assign M_Funct3    = r_funct3;
  assign M_MemRead   = r_mrd;
  assign M_MemWrite  = r_mwr;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level schedule model of the arbiter and memory.
module tb_data_mem_arbiter;
  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          C_Req, D_Req, C_MemRead, D_MemRead, C_MemWrite, D_MemWrite;
  logic [AW-1:0] C_Addr, D_Addr, M_Address;
  logic [DW-1:0] C_WData, D_WData, C_RData, D_RData, M_WriteData, M_ReadData;
  logic [2:0]    C_Funct3, D_Funct3, M_Funct3;
  logic          C_Gnt, D_Gnt, C_RValid, D_RValid, M_MemRead, M_MemWrite;
  logic [DW-1:0] mem [0:127];
  int            n_run = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .C_Req(C_Req), .C_Addr(C_Addr), .C_WData(C_WData), .C_MemRead(C_MemRead),
    .C_MemWrite(C_MemWrite), .C_Funct3(C_Funct3), .C_Gnt(C_Gnt), .C_RValid(C_RValid),
    .C_RData(C_RData),
    .D_Req(D_Req), .D_Addr(D_Addr), .D_WData(D_WData), .D_MemRead(D_MemRead),
    .D_MemWrite(D_MemWrite), .D_Funct3(D_Funct3), .D_Gnt(D_Gnt), .D_RValid(D_RValid),
    .D_RData(D_RData),
    .M_Address(M_Address), .M_WriteData(M_WriteData), .M_MemRead(M_MemRead),
    .M_MemWrite(M_MemWrite), .M_Funct3(M_Funct3), .M_ReadData(M_ReadData)
  );

  // Word-organized memory; Funct3 is not modelled, all accesses are full words.
  assign M_ReadData = mem[M_Address[AW-1:2]];
  always @(posedge clk) if (M_MemWrite) mem[M_Address[AW-1:2]] <= M_WriteData;

  task automatic drv_c(input logic req, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [2:0] f);
    C_Req = req; C_MemRead = rd; C_MemWrite = wr; C_Addr = a; C_WData = d; C_Funct3 = f;
  endtask

  task automatic drv_d(input logic req, input logic rd, input logic wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [2:0] f);
    D_Req = req; D_MemRead = rd; D_MemWrite = wr; D_Addr = a; D_WData = d; D_Funct3 = f;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    drv_c(0, 0, 0, '0, '0, '0);
    drv_d(0, 0, 0, '0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    drv_c(1, 1, 0, 9'h010, 32'h1, 3'd2);
    drv_d(1, 0, 1, 9'h020, 32'h2, 3'd2);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_run++; if ({C_Gnt, D_Gnt, C_RValid, D_RValid, M_MemRead, M_MemWrite} !== 6'b0) begin
      n_fail++; $display("FAIL reset_strobes got=%b exp=000000", {C_Gnt, D_Gnt, C_RValid, D_RValid, M_MemRead, M_MemWrite}); end
    n_run++; if ({C_RData, D_RData, M_WriteData} !== 96'b0) begin
      n_fail++; $display("FAIL reset_data got=%h %h %h exp=0", C_RData, D_RData, M_WriteData); end
    n_run++; if ({M_Address, M_Funct3} !== 12'b0) begin
      n_fail++; $display("FAIL reset_addr got=%h %h exp=0", M_Address, M_Funct3); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_run++; if ({C_Gnt, D_Gnt} !== 2'b10) begin
      n_fail++; $display("FAIL reset_first_gnt got=%b exp=10", {C_Gnt, D_Gnt}); end
  endtask

  task automatic test_core_lw;
    do_reset();
    mem[4] = 32'hDEADBEEF;
    drv_c(1, 1, 0, 9'h010, 32'h0, 3'b010);
    @(negedge clk);
    n_run++; if ({C_Gnt, D_Gnt, D_RValid} !== 3'b100) begin
      n_fail++; $display("FAIL lw_gnt got=%b exp=100", {C_Gnt, D_Gnt, D_RValid}); end
    step(); C_Req = 1'b0;
    @(negedge clk);
    n_run++; if ({M_MemRead, M_MemWrite, C_RValid, D_RValid} !== 4'b1000) begin
      n_fail++; $display("FAIL lw_cmd_strobe got=%b exp=1000", {M_MemRead, M_MemWrite, C_RValid, D_RValid}); end
    n_run++; if (M_Address !== 9'h010 || M_Funct3 !== 3'b010) begin
      n_fail++; $display("FAIL lw_cmd_addr got=%h/%b exp=010/010", M_Address, M_Funct3); end
    step();
    @(negedge clk);
    n_run++; if ({C_RValid, D_RValid, M_MemRead} !== 3'b100 || C_RData !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_resp got=%b data=%h exp=100 data=deadbeef", {C_RValid, D_RValid, M_MemRead}, C_RData); end
    step();
    @(negedge clk);
    n_run++; if (C_RValid !== 1'b0 || C_RData !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL lw_hold got=%b data=%h exp=0 data=deadbeef", C_RValid, C_RData); end
  endtask

  task automatic test_contention;
    do_reset();
    mem[8] = 32'h0;
    drv_c(1, 0, 1, 9'h040, 32'hC0C00001, 3'd2);
    drv_d(1, 0, 1, 9'h020, 32'h12345678, 3'd2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_run++; if ({C_Gnt, D_Gnt, M_MemWrite} !== {i % 4 == 0, i % 4 == 2, i % 2 == 1}) begin
        n_fail++; $display("FAIL cont_gnt cyc=%0d got=%b exp=%b", i, {C_Gnt, D_Gnt, M_MemWrite}, {i % 4 == 0, i % 4 == 2, i % 2 == 1}); end
      if (i == 7) begin
        n_run++; if (M_Address !== 9'h020 || M_WriteData !== 32'h12345678) begin
          n_fail++; $display("FAIL cont_dsw got=%h/%h exp=020/12345678", M_Address, M_WriteData); end
      end
      step();
    end
    C_Req = 1'b0;
    drv_d(1, 1, 0, 9'h020, 32'h0, 3'd2);
    @(negedge clk);
    n_run++; if ({C_Gnt, D_Gnt} !== 2'b01) begin
      n_fail++; $display("FAIL cont_dlw_gnt got=%b exp=01", {C_Gnt, D_Gnt}); end
    step(); D_Req = 1'b0;
    @(negedge clk);
    n_run++; if (M_MemRead !== 1'b1) begin
      n_fail++; $display("FAIL cont_dlw_cmd got=%b exp=1", M_MemRead); end
    step();
    @(negedge clk);
    n_run++; if ({D_RValid, C_RValid} !== 2'b10 || D_RData !== 32'h12345678) begin
      n_fail++; $display("FAIL cont_dlw_data got=%b data=%h exp=10 data=12345678", {D_RValid, C_RValid}, D_RData); end
  endtask

  task automatic test_back_to_back;
    logic [6:0] w;
    do_reset();
    for (int k = 0; k < 3; k++) mem[16 + k] = 32'hB0000000 + k;
    for (int i = 0; i < 9; i++) begin
      w = 7'(16 + i / 3);
      drv_c(1, 1, 0, {w, 2'b00}, 32'h0, 3'd2);
      @(negedge clk);
      n_run++; if ({C_Gnt, C_RValid, D_RValid} !== {i % 3 == 0, i % 3 == 2, 1'b0}) begin
        n_fail++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, {C_Gnt, C_RValid, D_RValid}, {i % 3 == 0, i % 3 == 2, 1'b0}); end
      if (i % 3 == 2) begin
        n_run++; if (C_RData !== 32'hB0000000 + 32'(i / 3)) begin
          n_fail++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", i, C_RData, 32'hB0000000 + 32'(i / 3)); end
      end
      step();
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drv_d(1, 1, 0, 9'h030, 32'h0, 3'd2);
    @(negedge clk);
    n_run++; if (D_Gnt !== 1'b1) begin
      n_fail++; $display("FAIL rmid_gnt got=%b exp=1", D_Gnt); end
    step(); D_Req = 1'b0;
    @(negedge clk);
    n_run++; if (M_MemRead !== 1'b1) begin
      n_fail++; $display("FAIL rmid_cmd got=%b exp=1", M_MemRead); end
    #2 rst_n = 1'b0;
    #1;
    n_run++; if (M_MemRead !== 1'b0) begin
      n_fail++; $display("FAIL rmid_async got=%b exp=0", M_MemRead); end
    step(); rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_run++; if ({D_RValid, M_MemRead} !== 2'b00) begin
        n_fail++; $display("FAIL rmid_norv cyc=%0d got=%b exp=00", i, {D_RValid, M_MemRead}); end
      step();
    end
    drv_c(1, 0, 1, 9'h000, 32'h0, 3'd2);
    D_Req = 1'b1;
    @(negedge clk);
    n_run++; if ({C_Gnt, D_Gnt} !== 2'b10) begin
      n_fail++; $display("FAIL rmid_idle got=%b exp=10", {C_Gnt, D_Gnt}); end
  endtask

  task automatic test_op_decode;
    do_reset();
    mem[17] = 32'h5555AAAA;
    drv_c(1, 1, 1, 9'h044, 32'hFFFF0000, 3'd2);
    @(negedge clk);
    n_run++; if (C_Gnt !== 1'b1) begin
      n_fail++; $display("FAIL rw_gnt got=%b exp=1", C_Gnt); end
    step(); C_Req = 1'b0;
    @(negedge clk);
    n_run++; if ({M_MemRead, M_MemWrite} !== 2'b10) begin
      n_fail++; $display("FAIL rw_prio got=%b exp=10", {M_MemRead, M_MemWrite}); end
    step();
    @(negedge clk);
    n_run++; if (C_RValid !== 1'b1 || C_RData !== 32'h5555AAAA) begin
      n_fail++; $display("FAIL rw_data got=%b/%h exp=1/5555aaaa", C_RValid, C_RData); end
    step();
    drv_c(1, 0, 0, 9'h048, 32'h0, 3'd0);
    @(negedge clk);
    n_run++; if (C_Gnt !== 1'b1) begin
      n_fail++; $display("FAIL null_gnt got=%b exp=1", C_Gnt); end
    step();
    @(negedge clk);
    n_run++; if ({C_Gnt, M_MemRead, M_MemWrite, C_RValid} !== 4'b0000) begin
      n_fail++; $display("FAIL null_cmd got=%b exp=0000", {C_Gnt, M_MemRead, M_MemWrite, C_RValid}); end
    step();
    @(negedge clk);
    n_run++; if ({C_Gnt, C_RValid} !== 2'b10) begin
      n_fail++; $display("FAIL null_next got=%b exp=10", {C_Gnt, C_RValid}); end
    step(); C_Req = 1'b0;
  endtask

  // Schedule model: a grant books the memory until a fixed future cycle and
  // records which strobe / response is due on which cycle.
  task automatic test_random;
    logic [DW-1:0] ref_mem [0:127];
    logic          preq [2], prd [2], pwr [2];
    logic [AW-1:0] paddr [2];
    logic [DW-1:0] pdata [2], e_rdata [2], rv_d, e_wdata;
    logic [2:0]    pf3 [2], e_f3;
    logic [AW-1:0] e_addr;
    logic [6:0]    w;
    logic [1:0]    eg, r;
    logic          last_d, cmd_rd, cmd_wr, rv_p, erv_c, erv_d;
    int            free_c, cmd_c, rv_c, p;
    do_reset();
    for (int i = 0; i < 128; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    for (int q = 0; q < 2; q++) begin
      preq[q] = 0; prd[q] = 0; pwr[q] = 0; paddr[q] = '0; pdata[q] = '0; pf3[q] = '0; e_rdata[q] = '0;
    end
    e_addr = '0; e_wdata = '0; e_f3 = '0; rv_d = '0;
    last_d = 1'b1; free_c = 0; cmd_c = -1; rv_c = -1; rv_p = 1'b0; cmd_rd = 1'b0; cmd_wr = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int q = 0; q < 2; q++) begin
        if (!preq[q] && $urandom_range(0, 1) == 1) begin
          r = 2'($urandom_range(0, 3));
          w = 7'($urandom_range(0, 127));
          preq[q] = 1; prd[q] = r[0]; pwr[q] = r[1]; paddr[q] = {w, 2'b00};
          pdata[q] = $urandom; pf3[q] = 3'($urandom_range(0, 7));
        end
      end
      drv_c(preq[0], prd[0], pwr[0], paddr[0], pdata[0], pf3[0]);
      drv_d(preq[1], prd[1], pwr[1], paddr[1], pdata[1], pf3[1]);
      @(negedge clk);
      eg = 2'b00;
      if (cyc >= free_c) begin
        if (preq[0] && (!preq[1] || last_d)) eg = 2'b01;
        else if (preq[1]) eg = 2'b10;
      end
      n_run++; if ({D_Gnt, C_Gnt} !== eg) begin
        n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, {D_Gnt, C_Gnt}, eg); end
      n_run++; if ({M_MemRead, M_MemWrite} !== {cyc == cmd_c && cmd_rd, cyc == cmd_c && cmd_wr}) begin
        n_fail++; $display("FAIL rnd_strobe cyc=%0d got=%b exp=%b", cyc, {M_MemRead, M_MemWrite}, {cyc == cmd_c && cmd_rd, cyc == cmd_c && cmd_wr}); end
      n_run++; if (M_Address !== e_addr || M_WriteData !== e_wdata || M_Funct3 !== e_f3) begin
        n_fail++; $display("FAIL rnd_cmdregs cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, M_Address, M_WriteData, M_Funct3, e_addr, e_wdata, e_f3); end
      erv_c = (cyc == rv_c) && !rv_p;
      erv_d = (cyc == rv_c) && rv_p;
      if (cyc == rv_c) e_rdata[rv_p] = rv_d;
      n_run++; if ({C_RValid, D_RValid} !== {erv_c, erv_d}) begin
        n_fail++; $display("FAIL rnd_rvalid cyc=%0d got=%b exp=%b", cyc, {C_RValid, D_RValid}, {erv_c, erv_d}); end
      n_run++; if (C_RData !== e_rdata[0] || D_RData !== e_rdata[1]) begin
        n_fail++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, C_RData, D_RData, e_rdata[0], e_rdata[1]); end
      if (eg != 2'b00) begin
        p = eg[1] ? 1 : 0;
        e_addr = paddr[p]; e_wdata = pdata[p]; e_f3 = pf3[p];
        last_d = eg[1];
        cmd_c = cyc + 1; cmd_rd = prd[p]; cmd_wr = !prd[p] && pwr[p];
        if (cmd_rd) begin
          rv_c = cyc + 2; rv_p = eg[1]; rv_d = ref_mem[paddr[p][AW-1:2]]; free_c = cyc + 3;
        end else begin
          free_c = cyc + 2;
        end
        if (cmd_wr) ref_mem[paddr[p][AW-1:2]] = pdata[p];
        preq[p] = 1'b0;
      end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    test_reset();
    test_core_lw();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    test_op_decode();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory. It shares the memory between the core load/store path (port C) and a DMA/debug master (port D). Each access runs through a fixed IDLE→CMD(→RESP) sequence, and a round-robin pointer grants alternately under contention. The memory-side outputs connect directly to the data memory's Address, WriteData, MemRead, MemWrite, Funct3 and ReadData pins.

## Interface
Parameters:
- ADDRESS_WIDTH, 9, byte address width passed to memory
- DATA_WIDTH, 32, data width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- C_Req, D_Req  in  1  access request; held with payload until Gnt sampled high
- C_Addr, D_Addr  in  ADDRESS_WIDTH  byte address
- C_WData, D_WData  in  DATA_WIDTH  store data
- C_MemRead, D_MemRead  in  1  load request
- C_MemWrite, D_MemWrite  in  1  store request
- C_Funct3, D_Funct3  in  3  load/store size code, passed through
- C_Gnt, D_Gnt  out  1  combinational; request accepted this cycle
- C_RValid, D_RValid  out  1  one-cycle pulse; load data valid
- C_RData, D_RData  out  DATA_WIDTH  registered load data
- M_Address  out  ADDRESS_WIDTH  memory address
- M_WriteData  out  DATA_WIDTH  memory write data
- M_MemRead, M_MemWrite  out  1  memory command strobes
- M_Funct3  out  3  memory size code
- M_ReadData  in  DATA_WIDTH  memory read data; valid by end of the CMD cycle

## Operation
- States: IDLE, CMD, RESP. Reset state is IDLE.
- IDLE:
  - If any Req is high, assert Gnt for the winner only.
  - On the edge, latch the winner's Addr, WData, Funct3, op and port id into command registers; go to CMD.
  - If no Req, stay in IDLE.
- Arbitration:
  - One requester: that requester wins.
  - Both requesters: the port not granted most recently wins.
  - Last-grant pointer resets to D, so C wins the first contention.
  - Pointer updates only on a grant.
- Op decode at latch time:
  - MemRead=1 → read, even if MemWrite=1 (read has priority).
  - MemWrite=1 alone → write.
  - Neither → null op: Gnt is still given, no memory strobe, no RValid.
- CMD (exactly 1 cycle):
  - M_Address, M_WriteData, M_Funct3 driven from the command registers.
  - M_MemRead=1 for a read; M_MemWrite=1 for a write.
  - Read → RESP, with M_ReadData captured into the owning port's RData at the end of CMD.
  - Write or null → IDLE.
- RESP (1 cycle):
  - Owning port's RValid=1; all M_ strobes 0.
  - Next state is IDLE.
- Outside CMD:
  - M_MemRead=M_MemWrite=0.
  - M_Address, M_WriteData, M_Funct3 hold their last latched values.
- RData of each port holds until that port's next read completes.
- Gnt is never asserted outside IDLE. A requester whose Req is raised in CMD or RESP waits.
- Reset values: state IDLE, all strobes/Gnt/RValid 0, RData 0, M_Address/M_WriteData/M_Funct3 0, pointer = D.
- Reset mid-operation: state returns to IDLE asynchronously and the in-flight access is dropped (no RValid). A write already strobed is not undone.

## Timing
- Read: Gnt in cycle T, M_MemRead in T+1, RValid and RData in T+2. Next grant possible in T+3.
- Write: Gnt in T, M_MemWrite in T+1. Next grant possible in T+2.
- Null op: Gnt in T, idle cycle T+1. Next grant possible in T+2.
- Gnt depends combinationally on Req and state only; there is no combinational path from M_ReadData to any output.

## Test plan
- Reset: hold rst_n=0 with both Req=1 → all outputs 0. First cycle after release, C_Gnt=1 and D_Gnt=0.
- Core LW: C_Req, C_Addr=0x010, C_Funct3=010, C_MemRead=1 at T; memory returns 0xDEADBEEF → C_Gnt@T, M_MemRead=1 with M_Address=0x010 @T+1, C_RValid=1 with C_RData=0xDEADBEEF @T+2, D_RValid=0 throughout.
- Contention: both Req held continuously with writes → grants alternate C, D, C, D every 2 cycles. D SW 0x12345678 to 0x020 is followed by a D LW of 0x020 that returns 0x12345678.
- Back-to-back core loads, D idle → C_Gnt every 3 cycles; each RValid pulse lasts exactly 1 cycle.
- rst_n dropped during CMD of a D read → M_MemRead falls immediately, D_RValid never pulses, state is IDLE after release.
- C_MemRead=C_MemWrite=1 → M_MemRead=1 and M_MemWrite=0 in CMD. C_MemRead=C_MemWrite=0 → Gnt given, no strobe, no RValid, next Gnt at T+2.
